// File: rtl/size_expr_serializer.sv
// size_expr_serializer: splits a paramB*paramA-bit word into paramA-bit beats, LSB beat first.
// Optional SIZE_EXPR_SERIALIZER_SKIP_EMPTY_EN suppresses beats whose strobe slice is all zero.
module size_expr_serializer #(
  parameter int paramA = 32,
  parameter int paramB = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [paramB * paramA - 1:0]   in_data,
  input  logic [paramB * (paramA / 8) - 1:0] in_strb,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [paramA - 1:0]            out_data,
  output logic [(paramA / 8) - 1:0]      out_strb,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int SW = paramA / 8;
  localparam int CW = (paramB > 1) ? $clog2(paramB) : 1;

  typedef logic [CW-1:0]     cnt_t;
  typedef logic [paramB-1:0] mask_t;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [paramB*paramA-1:0]   word_p0, word_d;
  logic [paramB*SW-1:0]       strb_p0, strb_d;
  mask_t                      mask_p0, mask_d;
  cnt_t                       cnt_p0, cnt_d;
  logic [paramA-1:0]          data_p1, data_d;
  logic [SW-1:0]              ostrb_p1, ostrb_d;
  logic                       last_p1, last_d;
  mask_t                      in_mask;
  int                         in_idx, nxt_idx;
  logic                       out_hs, in_acc;

  // Lowest set index at or above start, -1 when none.
  function automatic int first_set(input mask_t m, input int start);
    int    r;
    mask_t t;
    r = -1;
    for (int k = paramB - 1; k >= 0; k--) begin
      t = m >> k;
      if (k >= start && t[0]) r = k;
    end
    return r;
  endfunction

  function automatic int last_set(input mask_t m);
    int    r;
    mask_t t;
    r = -1;
    for (int k = 0; k < paramB; k++) begin
      t = m >> k;
      if (t[0]) r = k;
    end
    return r;
  endfunction

  function automatic logic [paramA-1:0] beat_data(input logic [paramB*paramA-1:0] w, input int k);
    int s;
    s = (k < 0) ? 0 : k;
    return paramA'(w >> (s * paramA));
  endfunction

  function automatic logic [SW-1:0] beat_strb(input logic [paramB*SW-1:0] w, input int k);
    int s;
    s = (k < 0) ? 0 : k;
    return SW'(w >> (s * SW));
  endfunction

`ifdef SIZE_EXPR_SERIALIZER_SKIP_EMPTY_EN
  function automatic mask_t beat_mask(input logic [paramB*SW-1:0] s);
    mask_t                m;
    logic [paramB*SW-1:0] t;
    m = '0;
    for (int k = 0; k < paramB; k++) begin
      t = s >> (k * SW);
      if (|t[SW-1:0]) m = m | (mask_t'(1) << k);
    end
    return m;
  endfunction

  assign in_mask = beat_mask(in_strb);
`else
  assign in_mask = '1;
`endif

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign out_hs    = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (out_hs && last_p1);
  assign in_acc    = in_valid && in_ready;
  assign out_data  = data_p1;
  assign out_strb  = ostrb_p1;
  assign out_last  = last_p1;

  always_comb begin
    state_d = state_q;
    word_d  = word_p0;
    strb_d  = strb_p0;
    mask_d  = mask_p0;
    cnt_d   = cnt_p0;
    data_d  = data_p1;
    ostrb_d = ostrb_p1;
    last_d  = last_p1;
    in_idx  = first_set(in_mask, 0);
    nxt_idx = first_set(mask_p0, int'(cnt_p0) + 1);
    if (in_acc) begin
      word_d = in_data;
      strb_d = in_strb;
      mask_d = in_mask;
      if (in_idx >= 0) begin
        state_d = SEND;
        cnt_d   = cnt_t'(in_idx);
        data_d  = beat_data(in_data, in_idx);
        ostrb_d = beat_strb(in_strb, in_idx);
        last_d  = (in_idx == last_set(in_mask));
      end else begin
        // Nothing to emit: the word is consumed without producing beats.
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
    end else if (out_hs) begin
      if (last_p1) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else begin
        cnt_d   = cnt_t'(nxt_idx);
        data_d  = beat_data(word_p0, nxt_idx);
        ostrb_d = beat_strb(strb_p0, nxt_idx);
        last_d  = (nxt_idx == last_set(mask_p0));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage p0: held word and beat index
  always_ff @(posedge clk) begin
    word_p0 <= word_d;
    strb_p0 <= strb_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_p0  <= '0;
      cnt_p0   <= '0;
      data_p1  <= '0;
      ostrb_p1 <= '0;
      last_p1  <= 1'b0;
    end else begin
      mask_p0  <= mask_d;
      cnt_p0   <= cnt_d;
      // Stage p1: registered beat outputs
      data_p1  <= data_d;
      ostrb_p1 <= ostrb_d;
      last_p1  <= last_d;
    end
  end

endmodule

// File: tb/tb_size_expr_serializer.sv
// Scoreboard bench for size_expr_serializer: a 32x4 instance and an 8x1 instance.
// Expectations adapt to SIZE_EXPR_SERIALIZER_SKIP_EMPTY_EN when that macro is defined.
module tb_size_expr_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] in_data;
  logic [15:0]  in_strb;
  logic         in_valid, in_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_strb;
  logic         out_last, out_valid, out_ready, busy;

  logic [7:0]   in_data1;
  logic [0:0]   in_strb1;
  logic         in_valid1, in_ready1;
  logic [7:0]   out_data1;
  logic [0:0]   out_strb1;
  logic         out_last1, out_valid1, out_ready1, busy1;

  size_expr_serializer #(.paramA(32), .paramB(4)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strb(in_strb), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  size_expr_serializer #(.paramA(8), .paramB(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_strb(in_strb1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_strb(out_strb1), .out_last(out_last1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  localparam logic [127:0] W  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] A5 = {4{32'hA5A5A5A5}};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs0   = 0;
  logic [36:0] q0[$];
  logic [9:0]  q1[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp0(input logic [31:0] d, input logic [3:0] s, input logic l);
    q0.push_back({d, s, l});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word on u0 and wait (bounded) for its accepting edge.
  task automatic send0(input logic [127:0] d, input logic [15:0] s, output int acc_cyc);
    logic r;
    r = 1'b0;
    in_data  = d;
    in_strb  = s;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) break;
    end
    if (!r) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    logic [36:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      hs0++;
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat0_extra: got %0h expected no beat", {out_data, out_strb, out_last});
      end else begin
        e = q0.pop_front();
        check("beat0", {out_data, out_strb, out_last}, e);
      end
    end
  end

  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat1_extra: got %0h expected no beat", {out_data1, out_strb1, out_last1});
      end else begin
        e = q1.pop_front();
        check("beat1", {out_data1, out_strb1, out_last1}, e);
      end
    end
  end

  initial begin
    int c0, c1, c2, h;
    rst = 1'b1;
    in_data = '0; in_strb = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_data1 = '0; in_strb1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_strb", out_strb, 4'h0);
    check("rst_valid1", out_valid1, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_ready", in_ready, 1'b1);

    // Basic word
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h22222222, 4'hF, 1'b0);
    exp0(32'h33333333, 4'hF, 1'b0); exp0(32'h44444444, 4'hF, 1'b1);
    send0(W, 16'hFFFF, c0);
    check("basic_lat_valid", out_valid, 1'b1);
    check("basic_lat_data", out_data, 32'h11111111);
    for (int i = 0; i < 3; i++) begin
      check("basic_ready_low", in_ready, 1'b0);
      check("basic_busy", busy, 1'b1);
      tick();
    end
    check("basic_last", out_last, 1'b1);
    tick();
    check("basic_idle", out_valid, 1'b0);
    check("basic_idle_last", out_last, 1'b0);

    // Backpressure on beat 1
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h22222222, 4'hF, 1'b0);
    exp0(32'h33333333, 4'hF, 1'b0); exp0(32'h44444444, 4'hF, 1'b1);
    send0(W, 16'hFFFF, c0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 32'h22222222);
      check("bp_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("bp_idle", out_valid, 1'b0);

    // Back-to-back words with no bubble
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h22222222, 4'hF, 1'b0);
    exp0(32'h33333333, 4'hF, 1'b0); exp0(32'h44444444, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) exp0(32'hA5A5A5A5, 4'hF, i == 3);
    send0(W, 16'hFFFF, c1);
    h = hs0;
    send0(A5, 16'hFFFF, c2);
    check("b2b_accept_cycle", c2 - c1, 4);
    for (int i = 0; i < 4; i++) tick();
    check("b2b_beats_8_cycles", hs0 - h, 8);
    check("b2b_idle", out_valid, 1'b0);

    // Reset in the middle of a word
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h22222222, 4'hF, 1'b0);
    send0(W, 16'hFFFF, c0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", out_data, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_still_idle", out_valid, 1'b0);
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h22222222, 4'hF, 1'b0);
    exp0(32'h33333333, 4'hF, 1'b0); exp0(32'h44444444, 4'hF, 1'b1);
    send0(W, 16'hFFFF, c0);
    check("midrst_restart", out_data, 32'h11111111);
    for (int i = 0; i < 4; i++) tick();

    // Sparse strobes 0x0F0F
`ifdef SIZE_EXPR_SERIALIZER_SKIP_EMPTY_EN
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h33333333, 4'hF, 1'b1);
    send0(W, 16'h0F0F, c0);
    tick();
    check("skip_last_beat", out_data, 32'h33333333);
    tick();
    check("skip_idle", out_valid, 1'b0);
    send0(W, 16'h0000, c0);
    check("empty_no_valid", out_valid, 1'b0);
    check("empty_ready", in_ready, 1'b1);
    tick();
    check("empty_still_idle", out_valid, 1'b0);
`else
    exp0(32'h11111111, 4'hF, 1'b0); exp0(32'h22222222, 4'h0, 1'b0);
    exp0(32'h33333333, 4'hF, 1'b0); exp0(32'h44444444, 4'h0, 1'b1);
    send0(W, 16'h0F0F, c0);
    tick();
    check("sparse_zero_beat", out_strb, 4'h0);
    for (int i = 0; i < 3; i++) tick();
    check("sparse_idle", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) exp0(32'hA5A5A5A5, 4'h0, i == 3);
    send0(A5, 16'h0000, c0);
    check("zero_strb_valid", out_valid, 1'b1);
    for (int i = 0; i < 4; i++) tick();
`endif

    // Single-beat instance streaming
    in_valid1 = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      in_data1 = 8'(v);
      q1.push_back({8'(v), 1'b1, 1'b1});
      #1;
      check("b1_ready", in_ready1, 1'b1);
      tick();
      if (v == 1) begin
        check("b1_latency", out_data1, 8'h01);
        check("b1_last", out_last1, 1'b1);
      end
    end
    in_valid1 = 1'b0;

    for (int n = 0; n < 20; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    tick();
    check("b1_idle", out_valid1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/size_expr_serializer.md
Name: size_expr_serializer

Overview:
- Transmit-side counterpart to the parameterised-width sink ports: drives a narrow paramA-bit beat stream from a wide paramB*paramA-bit word.
- Widths use the same size-expression family: paramA, paramA/8, paramB*paramA, paramB*(paramA/8).
- Sits between a wide producer and a narrow consumer.
- Valid/ready on both sides; zero-bubble back-to-back words.

Parameters:
- paramA, 32, beat data width in bits; multiple of 8, at least 8.
- paramB, 4, beats per input word; at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  [paramB * paramA - 1:0]  wide word; beat k = bits [k*paramA +: paramA].
- in_strb  input  [paramB * (paramA / 8) - 1:0]  byte enables; beat k = bits [k*(paramA/8) +: paramA/8].
- in_valid  input  1  word valid.
- in_ready  output  1  word accepted when in_valid && in_ready.
- out_data  output  [paramA - 1:0]  current beat.
- out_strb  output  [(paramA / 8) - 1:0]  current beat byte enables.
- out_last  output  1  final beat of the word.
- out_valid  output  1  beat valid.
- out_ready  input  1  beat consumed when out_valid && out_ready.
- busy  output  1  word held (equals out_valid).

Behaviour:
- Reset (async, immediate):
  - out_valid = 0, out_last = 0, busy = 0.
  - out_data and out_strb = 0; beat counter = 0; state = IDLE.
  - in_ready = 1 once rst deasserts.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On in accept at edge N: latch in_data and in_strb, counter = 0, go to SEND.
  - Beat 0 is valid from cycle N+1, so latency is 1 cycle.
- State SEND:
  - out_valid = 1; out_data and out_strb = latched slice[counter]. Beat 0 is the LSBs.
  - out_last = 1 iff counter == paramB-1.
  - On out handshake with counter < paramB-1: counter increments.
- Last-beat handshake (out handshake with out_last = 1):
  - If in_valid in the same cycle: accept the new word (in_ready = 1 combinationally in this case), counter = 0, stay in SEND. No bubble.
  - Otherwise go to IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). It is 0 during non-final beats.
- Output stability:
  - All out_* are registered.
  - While out_valid && !out_ready, out_data, out_strb and out_last hold stable.
  - out_valid never drops without a handshake, except on rst.
- Counter: $clog2(paramB) bits, minimum 1 bit. Never exceeds paramB-1; no wrap beyond it.
- paramB == 1: every beat has out_last = 1. The block acts as a one-deep registered pipeline stage at full throughput.
- Beats are emitted regardless of strobe value (strobe passes through unless the optional feature is enabled).
- Reset mid-word: the held word is discarded and no further beats are emitted. out_valid drops asynchronously.
- Throughput: paramB beats per word at 1 beat/cycle with out_ready held at 1.

Optional Feature:
- Macro: SIZE_EXPR_SERIALIZER_SKIP_EMPTY_EN.
- Enabled:
  - Beats whose strobe slice is all zero are not emitted; the counter advances directly to the next non-empty beat.
  - First emitted beat = lowest non-empty index.
  - out_last = 1 on the highest non-empty index.
  - A word with in_strb == 0 is accepted and dropped: no beats, in_ready stays 1.
  - Skipping costs no cycles (next-index selection is combinational from the strobe mask).
- Disabled: all paramB beats are always emitted, including all-zero-strobe beats.

Test Plan:
- Basic: paramA=32, paramB=4, in_data=0x44444444_33333333_22222222_11111111, in_strb=0xFFFF, out_ready=1.
  -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles N+1..N+4; out_strb=0xF each; out_last only on the 4th; in_ready low on cycles N+1..N+3.
- Backpressure: same word, out_ready low on beat 1 for 3 cycles.
  -> out_data holds 0x22222222 and out_valid stays 1 for those 3 cycles; 4 beats total, order unchanged.
- Back-to-back: two words driven continuously (second word all 0xA5A5A5A5), out_ready=1.
  -> 8 beats on 8 consecutive cycles; second word accepted on the same edge as the first word's out_last; no idle cycle.
- Reset mid-word: assert rst after beat 1 handshake.
  -> out_valid=0 immediately, no beats 2/3; after release, in_ready=1 and a new word serialises from beat 0.
- Strobe 0x0F0F:
  - Macro off: 4 beats with out_strb F, 0, F, 0; last on beat 3.
  - Macro on: only beats 0 and 2 emitted, last on beat 2.
  - Macro on, in_strb=0: word accepted, zero beats, out_valid stays 0.
- paramB=1, paramA=8: stream 0x01..0x05 with out_ready=1.
  -> outputs 0x01..0x05 one per cycle after 1-cycle latency; out_last=1 on every beat.
